// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Digits and overflow flag are registered and only updated when a conversion completes.
module bin2bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int SAT_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands
);

    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] SAT_U = 32'(SAT_VAL);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state, state_nxt;
    logic [BIN_W-1:0] v;
    logic             ovf_pend;
    logic [15:0]      scratch;
    logic [15:0]      scratch_adj;
    logic [CNT_W-1:0] cnt;
    logic             over;

    // Compare at 32 bits so a SAT_VAL wider than BIN_W never gets truncated.
    assign over = 32'(bin) > SAT_U;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)              state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1))   state_nxt = LOAD;
            LOAD:                            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state == IDLE);
    end

    // Add-3 correction, each nibble independent; the following shift carries.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every register here is small control/data state, so all of it is
        // reset; an aborted conversion must leave no stale digits behind.
        if (!rst) begin
            v         <= '0;
            ovf_pend  <= 1'b0;
            scratch   <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            ones      <= '0;
            tens      <= '0;
            hundreds  <= '0;
            thousands <= '0;
        end else begin
            done <= (state == LOAD);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        v        <= over ? BIN_W'(SAT_U) : bin;
                        ovf_pend <= over;
                        scratch  <= '0;
                        cnt      <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[14:0], v[BIN_W-1]};
                    v       <= v << 1;
                    cnt     <= cnt - CNT_W'(1);
                end
                LOAD: begin
                    thousands <= scratch[15:12];
                    hundreds  <= scratch[11:8];
                    tens      <= scratch[7:4];
                    ones      <= scratch[3:0];
                    ovf       <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: latency-level reference model compared every
// cycle, plus directed scenarios with hand-computed digit expectations.
module tb_bin2bcd_seq;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             start = 1'b0;
    logic             ready, done, ovf;
    logic [3:0]       ones, tens, hundreds, thousands;
    logic [15:0]      dig;

    int n_tests = 0;
    int n_fail  = 0;
    bit run     = 1'b0;

    bin2bcd_seq #(.BIN_W(BIN_W), .SAT_VAL(9999)) dut (
        .clk(clk), .rst(rst), .bin(bin), .start(start),
        .ready(ready), .done(done), .ovf(ovf),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
    );

    assign dig = {thousands, hundreds, tens, ones};

    always #5 clk = ~clk;

    // Decimal digits of the saturated value, by plain arithmetic.
    function automatic logic [15:0] bcd_of(input int b);
        int s;
        s = (b > 9999) ? 9999 : b;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a conversion accepted on an idle edge publishes its result
    // LAT edges later; while busy, start is ignored.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_pend = 0;
    logic        m_ready = 1'b1, m_done = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_dig = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_age = 0; m_done = 1'b0; m_ovf = 1'b0; m_dig = '0; m_ready = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_age++;
                if (m_age == LAT) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dig  = bcd_of(m_pend);
                    m_ovf  = (m_pend > 9999);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_pend = int'(bin);
            end
            m_ready = !m_busy;
        end
    end

    always @(negedge clk) begin
        if (run) check("model", {ready, done, ovf, 13'd0, dig}, {m_ready, m_done, m_ovf, 13'd0, m_dig});
    end

    // One conversion from idle; returns digits, ovf and edges from accept to done.
    task automatic do_conv(input logic [BIN_W-1:0] b, output logic [15:0] d,
                           output logic o, output int lat);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        #2 start = 1'b0;
        bin = ~b;
        lat = -1;
        d   = 'x;
        o   = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                d   = dig;
                o   = ovf;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] d;
        logic        o;
        int          lat, ndone, last_cyc, cyc;
        logic [15:0] seen;

        @(posedge clk);
        #1 run = 1'b1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done",  32'(done),  32'd0);
        check("reset_ovf",   32'(ovf),   32'd0);
        check("reset_digits", 32'(dig),  32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic conversion and latency
        do_conv(14'd1234, d, o, lat);
        check("t1_latency", 32'(lat), 32'd15);
        check("t1_digits",  32'(d),   32'h1234);
        check("t1_ovf",     32'(o),   32'd0);

        // 2: zero, max in-range, small
        do_conv(14'd0, d, o, lat);
        check("t2_zero", {o, 15'd0, d}, 32'h0000_0000);
        do_conv(14'd9999, d, o, lat);
        check("t2_9999", {o, 15'd0, d}, 32'h0000_9999);
        do_conv(14'd10, d, o, lat);
        check("t2_10",   {o, 15'd0, d}, 32'h0000_0010);

        // 3: saturation and overflow clear
        do_conv(14'd16383, d, o, lat);
        check("t3_sat", {o, 15'd0, d}, 32'h8000_9999);
        do_conv(14'd10000, d, o, lat);
        check("t3_sat_edge", {o, 15'd0, d}, 32'h8000_9999);
        do_conv(14'd5, d, o, lat);
        check("t3_clear", {o, 15'd0, d}, 32'h0000_0005);

        // 4: start during SHIFT is ignored
        start = 1'b1; bin = 14'd1234;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 start = 1'b1; bin = 14'd42;
        @(posedge clk);
        #2 start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                seen = dig;
            end
        end
        check("t4_one_done", 32'(ndone), 32'd1);
        check("t4_digits",   32'(seen),  32'h1234);

        // 5: reset mid-conversion aborts
        start = 1'b1; bin = 14'd8765;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_digits", 32'(dig),   32'h0);
        check("t5_rst_ready",  32'(ready), 32'd1);
        check("t5_rst_done",   32'(done),  32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);
        do_conv(14'd8765, d, o, lat);
        check("t5_after", {o, 15'd0, d}, 32'h0000_8765);

        // 6: start held high, bin stepping 0..20
        start = 1'b1;
        bin   = 14'd0;
        last_cyc = 0;
        cyc = 0;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            cyc++;
            #2 bin = 14'(k + 1);
            lat = -1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                cyc++;
                #1;
                if (done) begin
                    lat = i;
                    break;
                end
            end
            if (k == 20) start = 1'b0;
            check("t6_digits", 32'(dig), 32'(bcd_of(k)));
            if (k > 0) check("t6_period", 32'(cyc - last_cyc), 32'd16);
            last_cyc = cyc;
        end

        // Random values against the arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            logic [BIN_W-1:0] r;
            r = BIN_W'($urandom_range(0, 16383));
            do_conv(r, d, o, lat);
            check("rand", {7'd0, o, 8'(lat), d}, {7'd0, (int'(r) > 9999), 8'd15, bcd_of(int'(r))});
        end

        repeat (3) @(posedge clk);
        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
